// File: rtl/alu_exec_unit_if.sv
// Instruction, writeback, branch, peripheral and stack-status bundle for
// alu_exec_unit. The core or testbench drives the master side. The execute
// stage connects to the slave side.
interface alu_exec_unit_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int IP_WIDTH       = 16
);
  logic                      iValid;
  logic                      oReady;
  logic [5:0]                iOpcode;
  logic [REG_ADDR_WIDTH-1:0] iDest;
  logic [DATA_WIDTH-1:0]     iData1;
  logic [DATA_WIDTH-1:0]     iData0;
  logic [DATA_WIDTH-1:0]     iImm;
  logic [IP_WIDTH-1:0]       iIP;
  logic                      oWbValid;
  logic [REG_ADDR_WIDTH-1:0] oWbAddr;
  logic [DATA_WIDTH-1:0]     oWbData;
  logic                      oBranchValid;
  logic [IP_WIDTH-1:0]       oBranchTarget;
  logic                      oPeriphReq;
  logic [1:0]                oPeriphSel;
  logic [DATA_WIDTH-1:0]     oPeriphAddr;
  logic [DATA_WIDTH-1:0]     oPeriphData;
  logic                      iPeriphAck;
  logic                      oStackOvf;
  logic                      oStackUnf;

  modport master (
    output iValid, iOpcode, iDest, iData1, iData0, iImm, iIP, iPeriphAck,
    input  oReady, oWbValid, oWbAddr, oWbData, oBranchValid, oBranchTarget,
           oPeriphReq, oPeriphSel, oPeriphAddr, oPeriphData, oStackOvf, oStackUnf
  );

  modport slave (
    input  iValid, iOpcode, iDest, iData1, iData0, iImm, iIP, iPeriphAck,
    output oReady, oWbValid, oWbAddr, oWbData, oBranchValid, oBranchTarget,
           oPeriphReq, oPeriphSel, oPeriphAddr, oPeriphData, oStackOvf, oStackUnf
  );
endinterface

// File: rtl/alu_exec_unit.sv
// MiniAlu execute stage. It handles single-cycle ALU ops, branches, CALL/RET,
// and the internal hardware stack. MUL runs as an iterative shift-add.
// LED/LCD/VGA writes wait for a peripheral handshake.
// Optional feature macro: ALU_EXEC_SAT_EN. When it is defined, ADD/ADDI
// saturate and SUB clamps at zero.
module alu_exec_unit #(
  parameter int                        DATA_WIDTH     = 16,
  parameter int                        REG_ADDR_WIDTH = 8,
  parameter int                        IP_WIDTH       = 16,
  parameter int                        STACK_DEPTH    = 16,
  parameter logic [REG_ADDR_WIDTH-1:0] RA_ADDR        = 8'd31
) (
  input logic            Clock,
  input logic            Reset,
  alu_exec_unit_if.slave bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd2,  OP_AND = 6'd3,
    OP_OR   = 6'd4,  OP_NOR  = 6'd5,  OP_ADDI = 6'd6,  OP_MUL = 6'd7,
    OP_STO  = 6'd8,  OP_BLE  = 6'd9,  OP_BEQ  = 6'd10, OP_JMP = 6'd11,
    OP_CALL = 6'd12, OP_RET  = 6'd13, OP_PUSH = 6'd14, OP_POP = 6'd15,
    OP_LED  = 6'd16, OP_LCD  = 6'd17, OP_VGA  = 6'd18
  } opcode_e;

  typedef enum logic [1:0] {IDLE, MUL, PERIPH} state_e;

  state_e                    state;
  logic                      readyQ;
  logic                      wbValidQ;
  logic [REG_ADDR_WIDTH-1:0] wbAddrQ;
  logic [DATA_WIDTH-1:0]     wbDataQ;
  logic                      brValidQ;
  logic [IP_WIDTH-1:0]       brTargetQ;
  logic                      periphReqQ;
  logic [1:0]                periphSelQ;
  logic [DATA_WIDTH-1:0]     periphAddrQ;
  logic [DATA_WIDTH-1:0]     periphDataQ;
  logic                      ovfQ;
  logic                      unfQ;

  logic [DATA_WIDTH-1:0]     mulAcc;
  logic [DATA_WIDTH-1:0]     mulCand;
  logic [DATA_WIDTH-1:0]     mulPlier;
  logic [CNT_W-1:0]          mulCount;
  logic [REG_ADDR_WIDTH-1:0] mulDest;
  logic [DATA_WIDTH-1:0]     mulNext;

  logic [DATA_WIDTH-1:0]     stackMem [STACK_DEPTH];
  logic [SP_W-1:0]           sp;
  logic [SP_W-1:0]           spM1;
  logic                      stackFull;
  logic                      stackEmpty;
  logic                      stackPush;

  logic                      accept;
  logic [DATA_WIDTH-1:0]     addRes;
  logic [DATA_WIDTH-1:0]     addiRes;
  logic [DATA_WIDTH-1:0]     subRes;
  logic                      aluWb;
  logic [REG_ADDR_WIDTH-1:0] aluAddr;
  logic [DATA_WIDTH-1:0]     aluData;
  logic                      brTake;
  logic [IP_WIDTH-1:0]       brTarget;

  assign accept     = bus.iValid & readyQ & (state == IDLE);
  assign spM1       = sp - 1'b1;
  assign stackFull  = (sp == SP_W'(STACK_DEPTH));
  assign stackEmpty = (sp == '0);
  assign stackPush  = accept & (bus.iOpcode == OP_PUSH) & ~stackFull;
  assign mulNext    = mulAcc + (mulPlier[0] ? mulCand : '0);

`ifdef ALU_EXEC_SAT_EN
  logic [DATA_WIDTH:0] addWide;
  logic [DATA_WIDTH:0] addiWide;
  assign addWide  = {1'b0, bus.iData1} + {1'b0, bus.iData0};
  assign addiWide = {1'b0, bus.iData1} + {1'b0, bus.iImm};
  assign addRes   = addWide[DATA_WIDTH]  ? '1 : addWide[DATA_WIDTH-1:0];
  assign addiRes  = addiWide[DATA_WIDTH] ? '1 : addiWide[DATA_WIDTH-1:0];
  assign subRes   = (bus.iData1 < bus.iData0) ? '0 : bus.iData1 - bus.iData0;
`else
  assign addRes   = bus.iData1 + bus.iData0;
  assign addiRes  = bus.iData1 + bus.iImm;
  assign subRes   = bus.iData1 - bus.iData0;
`endif

  // Decode the single-cycle result and the branch decision for the presented instruction
  always_comb begin
    aluWb    = 1'b0;
    aluAddr  = bus.iDest;
    aluData  = '0;
    brTake   = 1'b0;
    brTarget = IP_WIDTH'(bus.iDest);
    case (bus.iOpcode)
      OP_ADD:  begin aluWb = 1'b1; aluData = addRes; end
      OP_SUB:  begin aluWb = 1'b1; aluData = subRes; end
      OP_AND:  begin aluWb = 1'b1; aluData = bus.iData1 & bus.iData0; end
      OP_OR:   begin aluWb = 1'b1; aluData = bus.iData1 | bus.iData0; end
      OP_NOR:  begin aluWb = 1'b1; aluData = ~(bus.iData1 | bus.iData0); end
      OP_ADDI: begin aluWb = 1'b1; aluData = addiRes; end
      OP_STO:  begin aluWb = 1'b1; aluData = bus.iImm; end
      OP_BLE:  brTake = (bus.iData1 <= bus.iData0);
      OP_BEQ:  brTake = (bus.iData1 == bus.iData0);
      OP_JMP:  brTake = 1'b1;
      OP_CALL: begin
        aluWb   = 1'b1;
        aluAddr = RA_ADDR;
        aluData = DATA_WIDTH'(IP_WIDTH'(bus.iIP + 1'b1));
        brTake  = 1'b1;
      end
      OP_RET:  begin brTake = 1'b1; brTarget = IP_WIDTH'(bus.iData0); end
      OP_POP:  begin
        aluWb   = 1'b1;
        aluData = stackEmpty ? '0 : stackMem[spM1[SP_W-2:0]];
      end
      default: ;
    endcase
  end

  // Stack storage has no reset. The pointer and the flags reset in the control block.
  always_ff @(posedge Clock) begin
    if (stackPush) stackMem[sp[SP_W-2:0]] <= bus.iData0;
  end

  // Control FSM with registered outputs. Writeback and branch outputs are one-cycle strobes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      readyQ      <= 1'b0;
      wbValidQ    <= 1'b0;
      wbAddrQ     <= '0;
      wbDataQ     <= '0;
      brValidQ    <= 1'b0;
      brTargetQ   <= '0;
      periphReqQ  <= 1'b0;
      periphSelQ  <= '0;
      periphAddrQ <= '0;
      periphDataQ <= '0;
      ovfQ        <= 1'b0;
      unfQ        <= 1'b0;
      sp          <= '0;
      mulAcc      <= '0;
      mulCand     <= '0;
      mulPlier    <= '0;
      mulCount    <= '0;
      mulDest     <= '0;
    end else begin
      wbValidQ <= 1'b0;
      brValidQ <= 1'b0;
      case (state)
        IDLE: begin
          readyQ <= 1'b1;
          if (accept) begin
            if (aluWb) begin
              wbValidQ <= 1'b1;
              wbAddrQ  <= aluAddr;
              wbDataQ  <= aluData;
            end
            if (brTake) begin
              brValidQ  <= 1'b1;
              brTargetQ <= brTarget;
            end
            case (bus.iOpcode)
              OP_MUL: begin
                state    <= MUL;
                readyQ   <= 1'b0;
                mulAcc   <= '0;
                mulCand  <= bus.iData1;
                mulPlier <= bus.iData0;
                mulCount <= '0;
                mulDest  <= bus.iDest;
              end
              OP_LED, OP_LCD, OP_VGA: begin
                state       <= PERIPH;
                readyQ      <= 1'b0;
                periphReqQ  <= 1'b1;
                periphSelQ  <= 2'(bus.iOpcode - OP_LED);
                periphAddrQ <= bus.iData0;
                periphDataQ <= bus.iData1;
              end
              OP_PUSH: begin
                if (stackFull) ovfQ <= 1'b1;
                else           sp   <= sp + 1'b1;
              end
              OP_POP: begin
                if (stackEmpty) unfQ <= 1'b1;
                else            sp   <= spM1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          // The last step writes back directly. This keeps the total latency at DATA_WIDTH+1.
          mulAcc   <= mulNext;
          mulCand  <= mulCand << 1;
          mulPlier <= mulPlier >> 1;
          mulCount <= mulCount + 1'b1;
          if (mulCount == CNT_W'(DATA_WIDTH - 1)) begin
            wbValidQ <= 1'b1;
            wbAddrQ  <= mulDest;
            wbDataQ  <= mulNext;
            state    <= IDLE;
            readyQ   <= 1'b1;
          end
        end
        PERIPH: begin
          if (bus.iPeriphAck) begin
            periphReqQ <= 1'b0;
            state      <= IDLE;
            readyQ     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oReady        = readyQ;
  assign bus.oWbValid      = wbValidQ;
  assign bus.oWbAddr       = wbAddrQ;
  assign bus.oWbData       = wbDataQ;
  assign bus.oBranchValid  = brValidQ;
  assign bus.oBranchTarget = brTargetQ;
  assign bus.oPeriphReq    = periphReqQ;
  assign bus.oPeriphSel    = periphSelQ;
  assign bus.oPeriphAddr   = periphAddrQ;
  assign bus.oPeriphData   = periphDataQ;
  assign bus.oStackOvf     = ovfQ;
  assign bus.oStackUnf     = unfQ;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard testbench for alu_exec_unit. Stimulus pushes the expected
// writeback and branch events into queues. A negedge monitor pops those
// queues and compares them to the DUT outputs, including the cycle stamp.
module tb_alu_exec_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int unsigned cyc = 0;
  int unsigned compared = 0;
  int unsigned mismatched = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int unsigned when;
  } wb_exp_t;

  typedef struct {
    logic [15:0] target;
    int unsigned when;
  } br_exp_t;

  wb_exp_t wbQ[$];
  br_exp_t brQ[$];

  alu_exec_unit_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(8), .IP_WIDTH(16)) bus ();

  alu_exec_unit #(
    .DATA_WIDTH(16), .REG_ADDR_WIDTH(8), .IP_WIDTH(16), .STACK_DEPTH(16), .RA_ADDR(8'd31)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every writeback or branch strobe must match the oldest expected entry
  wb_exp_t mw;
  br_exp_t mb;
  always @(negedge Clock) begin
    if (Reset) begin
      if (bus.oWbValid) begin
        compared++;
        if (wbQ.size() == 0) begin
          mismatched++;
          $display("FAIL wb_unexpected: got addr %0h data %0h expected no writeback", bus.oWbAddr, bus.oWbData);
        end else begin
          mw = wbQ.pop_front();
          if (bus.oWbAddr !== mw.addr || bus.oWbData !== mw.data || cyc != mw.when) begin
            mismatched++;
            $display("FAIL wb: got addr %0h data %0h cycle %0d expected addr %0h data %0h cycle %0d",
                     bus.oWbAddr, bus.oWbData, cyc, mw.addr, mw.data, mw.when);
          end
        end
      end
      if (bus.oBranchValid) begin
        compared++;
        if (brQ.size() == 0) begin
          mismatched++;
          $display("FAIL br_unexpected: got target %0h expected no branch", bus.oBranchTarget);
        end else begin
          mb = brQ.pop_front();
          if (bus.oBranchTarget !== mb.target || cyc != mb.when) begin
            mismatched++;
            $display("FAIL br: got target %0h cycle %0d expected target %0h cycle %0d",
                     bus.oBranchTarget, cyc, mb.target, mb.when);
          end
        end
      end
    end
  end

  // Called at a negedge. Holds iValid until the instruction is accepted and records the expected results.
  task automatic issue(input logic [5:0] op, input logic [7:0] dest, input logic [15:0] d1,
                       input logic [15:0] d0, input logic [15:0] imm, input logic [15:0] ip,
                       input bit expWb, input logic [7:0] wa, input logic [15:0] wd,
                       input bit expBr, input logic [15:0] bt, input int unsigned lat,
                       output int unsigned waited);
    wb_exp_t w;
    br_exp_t b;
    bus.iOpcode = op; bus.iDest = dest; bus.iData1 = d1; bus.iData0 = d0;
    bus.iImm = imm; bus.iIP = ip; bus.iValid = 1'b1;
    waited = 0;
    while (!bus.oReady && waited < 200) begin
      @(negedge Clock);
      waited++;
    end
    if (!bus.oReady) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: got oReady 0 for %0d cycles expected 1", waited);
      bus.iValid = 1'b0;
    end else begin
      if (expWb) begin w.addr = wa; w.data = wd; w.when = cyc + lat; wbQ.push_back(w); end
      if (expBr) begin b.target = bt; b.when = cyc + lat; brQ.push_back(b); end
      @(posedge Clock);
      @(negedge Clock);
    end
  endtask

  task automatic alu(input logic [5:0] op, input logic [7:0] dest, input logic [15:0] d1,
                     input logic [15:0] d0, input logic [15:0] imm, input logic [15:0] exp);
    int unsigned w;
    issue(op, dest, d1, d0, imm, 16'd0, 1'b1, dest, exp, 1'b0, 16'd0, 1, w);
  endtask

  task automatic branch(input logic [5:0] op, input logic [7:0] dest, input logic [15:0] d1,
                        input logic [15:0] d0, input bit taken);
    int unsigned w;
    issue(op, dest, d1, d0, 16'd0, 16'd0, 1'b0, 8'd0, 16'd0, taken, {8'd0, dest}, 1, w);
  endtask

  task automatic noWb(input logic [5:0] op, input logic [15:0] d1, input logic [15:0] d0);
    int unsigned w;
    issue(op, 8'd0, d1, d0, 16'd0, 16'd0, 1'b0, 8'd0, 16'd0, 1'b0, 16'd0, 1, w);
  endtask

  int unsigned waited;
  logic [63:0] periphHeld;

  initial begin
    bus.iValid = 1'b0; bus.iOpcode = '0; bus.iDest = '0; bus.iData1 = '0;
    bus.iData0 = '0; bus.iImm = '0; bus.iIP = '0; bus.iPeriphAck = 1'b0;

    // Reset state
    @(negedge Clock);
    check("reset_outputs", {bus.oReady, bus.oWbValid, bus.oBranchValid, bus.oPeriphReq,
                            bus.oStackOvf, bus.oStackUnf, bus.oWbData}, 64'd0);
    Reset = 1'b1;
    #1 check("ready_low_after_release", {63'd0, bus.oReady}, 64'd0);
    @(negedge Clock);
    check("ready_first_edge", {63'd0, bus.oReady}, 64'd1);

    // Single-cycle ALU ops, issued back to back
`ifdef ALU_EXEC_SAT_EN
    alu(6'd1, 8'd1, 16'hFFFF, 16'd2, 16'd0, 16'hFFFF);
    alu(6'd2, 8'd2, 16'd5, 16'd7, 16'd0, 16'h0000);
    alu(6'd6, 8'd6, 16'h0064, 16'd0, 16'hFFF0, 16'hFFFF);
`else
    alu(6'd1, 8'd1, 16'hFFFF, 16'd2, 16'd0, 16'h0001);
    alu(6'd2, 8'd2, 16'd5, 16'd7, 16'd0, 16'hFFFE);
    alu(6'd6, 8'd6, 16'h0064, 16'd0, 16'hFFF0, 16'h0054);
`endif
    alu(6'd3, 8'd3, 16'hF0F0, 16'h3C3C, 16'd0, 16'h3030);
    alu(6'd4, 8'd4, 16'hF0F0, 16'h0F01, 16'd0, 16'hFFF1);
    alu(6'd5, 8'd5, 16'hF0F0, 16'h0F00, 16'd0, 16'h000F);
    alu(6'd8, 8'd8, 16'h1111, 16'h2222, 16'h1234, 16'h1234);
    noWb(6'd0, 16'd1, 16'd2);
    noWb(6'd20, 16'd1, 16'd2);

    // Branches: equality and unsigned boundaries
    branch(6'd9, 8'h55, 16'd3, 16'd3, 1'b1);
    branch(6'd9, 8'h56, 16'd4, 16'd3, 1'b0);
    branch(6'd9, 8'h57, 16'd0, 16'hFFFF, 1'b1);
    branch(6'd10, 8'hAA, 16'd9, 16'd9, 1'b1);
    branch(6'd10, 8'hAB, 16'd9, 16'd8, 1'b0);
    branch(6'd11, 8'hFF, 16'd0, 16'd0, 1'b1);

    // CALL then RET
    issue(6'd12, 8'd100, 16'd0, 16'd0, 16'd0, 16'd40, 1'b1, 8'd31, 16'd41, 1'b1, 16'd100, 1, waited);
    issue(6'd13, 8'd0, 16'd0, 16'd41, 16'd0, 16'd50, 1'b0, 8'd0, 16'd0, 1'b1, 16'd41, 1, waited);

    // MUL: latency 17. The following ADD is held waiting until ready returns.
    issue(6'd7, 8'd3, 16'd300, 16'd7, 16'd0, 16'd0, 1'b1, 8'd3, 16'd2100, 1'b0, 16'd0, 17, waited);
    issue(6'd1, 8'd4, 16'd10, 16'd20, 16'd0, 16'd0, 1'b1, 8'd4, 16'd30, 1'b0, 16'd0, 1, waited);
    check("mul_ready_low_cycles", 64'(waited), 64'd16);
    issue(6'd7, 8'd9, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 1'b1, 8'd9, 16'h0001, 1'b0, 16'd0, 17, waited);

    // Stack: 16 pushes fill it and the 17th overflows
    for (int i = 1; i <= 16; i++) noWb(6'd14, 16'd0, 16'(i));
    check("ovf_at_full", {63'd0, bus.oStackOvf}, 64'd0);
    noWb(6'd14, 16'd0, 16'd17);
    check("ovf_sticky", {63'd0, bus.oStackOvf}, 64'd1);
    for (int i = 16; i >= 1; i--) alu(6'd15, 8'd7, 16'd0, 16'd0, 16'd0, 16'(i));
    check("unf_before_empty_pop", {63'd0, bus.oStackUnf}, 64'd0);
    alu(6'd15, 8'd7, 16'd0, 16'd0, 16'd0, 16'd0);
    check("unf_sticky", {63'd0, bus.oStackUnf}, 64'd1);
    bus.iValid = 1'b0;

    // VGA with the ack delayed 5 cycles
    noWb(6'd18, 16'b101, 16'd37);
    bus.iValid = 1'b0;
    check("vga_ready_low", {63'd0, bus.oReady}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      periphHeld = {29'd0, bus.oPeriphReq, bus.oPeriphSel, bus.oPeriphAddr, bus.oPeriphData};
      check("vga_hold", periphHeld, {29'd0, 1'b1, 2'd2, 16'd37, 16'd5});
      if (i < 4) @(negedge Clock);
    end
    bus.iPeriphAck = 1'b1;
    @(negedge Clock);
    bus.iPeriphAck = 1'b0;
    check("vga_after_ack", {62'd0, bus.oPeriphReq, bus.oReady}, 64'd1);

    // LED with the ack already high: it is ignored in IDLE, so the request lasts one cycle
    bus.iPeriphAck = 1'b1;
    noWb(6'd16, 16'hBEEF, 16'd0);
    bus.iValid = 1'b0;
    check("led_req", {61'd0, bus.oPeriphReq, bus.oPeriphSel}, {61'd0, 1'b1, 2'd0});
    @(negedge Clock);
    bus.iPeriphAck = 1'b0;
    check("led_done", {62'd0, bus.oPeriphReq, bus.oReady}, 64'd1);

    // Reset during MUL aborts the multiply with no writeback
    issue(6'd7, 8'd2, 16'd123, 16'd45, 16'd0, 16'd0, 1'b0, 8'd0, 16'd0, 1'b0, 16'd0, 17, waited);
    bus.iValid = 1'b0;
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    #1 check("reset_mid_mul", {bus.oReady, bus.oWbValid, bus.oPeriphReq, bus.oStackOvf,
                               bus.oStackUnf, bus.oWbAddr, bus.oWbData}, 64'd0);
    repeat (20) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    alu(6'd1, 8'd12, 16'd2, 16'd3, 16'd0, 16'd5);
    bus.iValid = 1'b0;

    repeat (25) @(negedge Clock);
    check("wb_queue_drained", 64'(wbQ.size()), 64'd0);
    check("br_queue_drained", 64'(brQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

endmodule
